// File: rtl/painter_pkg.sv
// Shared screen geometry, colour constants and arbiter state encoding for the
// painting clients and paint_arbiter.
package painter_pkg;

    localparam int SCR_WIDTH  = 160;
    localparam int SCR_HEIGHT = 120;
    localparam int X_BITS     = 8;
    localparam int Y_BITS     = 7;
    localparam int ADDR_BITS  = 15;

    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_BLUE   = 3'b001;
    localparam logic [2:0] COLOR_YELLOW = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rect_fill_engine.sv
// Raster walker for one latched rectangle: issues one framebuffer write per
// cycle while fill is high and flags the final pixel of the job.
module rect_fill_engine #(
    parameter int SCR_WIDTH = 160,
    parameter int X_BITS    = 8,
    parameter int Y_BITS    = 7,
    parameter int ADDR_BITS = 15
) (
    input  logic                 Clck,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 fill,
    input  logic [X_BITS-1:0]    start_x,
    input  logic [Y_BITS-1:0]    start_y,
    input  logic [X_BITS-1:0]    x0,
    input  logic [X_BITS-1:0]    x1,
    input  logic [Y_BITS-1:0]    y1,
    output logic [ADDR_BITS-1:0] address,
    output logic                 print_enable,
    output logic                 last_pixel
);

    localparam logic [ADDR_BITS-1:0] SCR_W_A = ADDR_BITS'(SCR_WIDTH);

    logic [X_BITS-1:0]    cx_q, cx_d;
    logic [Y_BITS-1:0]    cy_q, cy_d;
    logic [ADDR_BITS-1:0] address_q, address_d;
    logic                 print_enable_q, print_enable_d;
    logic [X_BITS-1:0]    x_last;
    logic [Y_BITS-1:0]    y_last;
    logic [ADDR_BITS-1:0] pixel_addr;

    // Non-empty jobs are guaranteed by the arbiter, so x1/y1 are at least 1 here.
    assign x_last     = x1 - 1'b1;
    assign y_last     = y1 - 1'b1;
    assign pixel_addr = ADDR_BITS'(cx_q) + ADDR_BITS'(cy_q) * SCR_W_A;
    assign last_pixel = fill && (cx_q == x_last) && (cy_q == y_last);

    always_comb begin
        cx_d           = cx_q;
        cy_d           = cy_q;
        address_d      = address_q;
        print_enable_d = 1'b0;
        if (start) begin
            cx_d = start_x;
            cy_d = start_y;
        end else if (fill) begin
            address_d      = pixel_addr;
            print_enable_d = 1'b1;
            if (cx_q == x_last) begin
                cx_d = x0;
                cy_d = cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            cx_q           <= '0;
            cy_q           <= '0;
            address_q      <= '0;
            print_enable_q <= 1'b0;
        end else begin
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            address_q      <= address_d;
            print_enable_q <= print_enable_d;
        end
    end

    assign address      = address_q;
    assign print_enable = print_enable_q;

endmodule

// File: rtl/paint_arbiter.sv
// Round-robin owner of the rectangle-fill engine and the framebuffer write port.
// Define PAINT_ARBITER_CLIP_EN to clamp every job to the visible screen.
module paint_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SCR_WIDTH  = painter_pkg::SCR_WIDTH,
    parameter int SCR_HEIGHT = painter_pkg::SCR_HEIGHT,
    parameter int X_BITS     = painter_pkg::X_BITS,
    parameter int Y_BITS     = painter_pkg::Y_BITS,
    parameter int ADDR_BITS  = painter_pkg::ADDR_BITS
) (
    input  logic                      Clck,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*X_BITS-1:0] req_x0,
    input  logic [NUM_REQ*X_BITS-1:0] req_x1,
    input  logic [NUM_REQ*Y_BITS-1:0] req_y0,
    input  logic [NUM_REQ*Y_BITS-1:0] req_y1,
    input  logic [NUM_REQ*3-1:0]      req_color,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [ADDR_BITS-1:0]      address,
    output logic [2:0]                color,
    output logic                      print_enable
);
    import painter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [X_BITS-1:0] x0_a  [NUM_REQ];
    logic [X_BITS-1:0] x1_a  [NUM_REQ];
    logic [Y_BITS-1:0] y0_a  [NUM_REQ];
    logic [Y_BITS-1:0] y1_a  [NUM_REQ];
    logic [2:0]        col_a [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign x0_a[gi]  = req_x0[gi*X_BITS +: X_BITS];
        assign x1_a[gi]  = req_x1[gi*X_BITS +: X_BITS];
        assign y0_a[gi]  = req_y0[gi*Y_BITS +: Y_BITS];
        assign y1_a[gi]  = req_y1[gi*Y_BITS +: Y_BITS];
        assign col_a[gi] = req_color[gi*3 +: 3];
    end

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [X_BITS-1:0]    jx0_q, jx0_d;
    logic [X_BITS-1:0]    jx1_q, jx1_d;
    logic [Y_BITS-1:0]    jy1_q, jy1_d;
    logic [2:0]           jcolor_q, jcolor_d;
    logic [2:0]           color_q, color_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    int                   cand;
    logic [X_BITS-1:0]    sel_x0, sel_x1;
    logic [Y_BITS-1:0]    sel_y0, sel_y1;
    logic                 sel_empty;
    logic                 eng_start;
    logic                 eng_fill;
    logic                 last_pixel;

    // Search starts one past the previous winner so every waiting client is served in turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant_q) + k) % NUM_REQ;
            if (!grant_found && req[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

`ifdef PAINT_ARBITER_CLIP_EN
    localparam logic [X_BITS:0] X_LIM = (X_BITS+1)'(SCR_WIDTH);
    localparam logic [Y_BITS:0] Y_LIM = (Y_BITS+1)'(SCR_HEIGHT);
`endif

    always_comb begin
        sel_x0 = x0_a[grant_idx];
        sel_x1 = x1_a[grant_idx];
        sel_y0 = y0_a[grant_idx];
        sel_y1 = y1_a[grant_idx];
`ifdef PAINT_ARBITER_CLIP_EN
        // An origin at or past the edge becomes empty once the end is clamped.
        if ({1'b0, sel_x1} > X_LIM) sel_x1 = X_LIM[X_BITS-1:0];
        if ({1'b0, sel_y1} > Y_LIM) sel_y1 = Y_LIM[Y_BITS-1:0];
`endif
        sel_empty = (sel_x1 <= sel_x0) || (sel_y1 <= sel_y0);
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        jx0_d        = jx0_q;
        jx1_d        = jx1_q;
        jy1_d        = jy1_q;
        jcolor_d     = jcolor_q;
        color_d      = color_q;
        done_d       = '0;
        eng_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    eng_start = 1'b1;
                    winner_d  = grant_idx;
                    jx0_d     = sel_x0;
                    jx1_d     = sel_x1;
                    jy1_d     = sel_y1;
                    jcolor_d  = col_a[grant_idx];
                    state_d   = sel_empty ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                color_d = jcolor_q;
                if (last_pixel) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d[winner_q] = 1'b1;
                last_grant_d     = winner_q;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            winner_q     <= '0;
            jx0_q        <= '0;
            jx1_q        <= '0;
            jy1_q        <= '0;
            jcolor_q     <= COLOR_BLACK;
            color_q      <= COLOR_BLACK;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            jx0_q        <= jx0_d;
            jx1_q        <= jx1_d;
            jy1_q        <= jy1_d;
            jcolor_q     <= jcolor_d;
            color_q      <= color_d;
            done_q       <= done_d;
        end
    end

    assign eng_fill = (state_q == ST_FILL);

    rect_fill_engine #(
        .SCR_WIDTH (SCR_WIDTH),
        .X_BITS    (X_BITS),
        .Y_BITS    (Y_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_engine (
        .Clck         (Clck),
        .Reset        (Reset),
        .start        (eng_start),
        .fill         (eng_fill),
        .start_x      (sel_x0),
        .start_y      (sel_y0),
        .x0           (jx0_q),
        .x1           (jx1_q),
        .y1           (jy1_q),
        .address      (address),
        .print_enable (print_enable),
        .last_pixel   (last_pixel)
    );

    assign done  = done_q;
    assign color = color_q;
    assign busy  = (state_q != ST_IDLE);

endmodule
